// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending machine credit/dispense/change sequencer
module vend_sequencer #(
    parameter int PRICE0  = 3,
    parameter int PRICE1  = 4,
    parameter int PRICE2  = 6,
    parameter int PRICE3  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       disp_ack,
    input  logic       chg_ack,
    output logic       disp_req,
    output logic [1:0] disp_item,
    output logic       chg_req,
    output logic [4:0] credit,
    output logic       ready,
    output logic       coin_rej,
    output logic       no_funds,
    output logic       err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t        r_state, w_state;
    logic [4:0]    r_credit, w_credit;
    logic          r_disp_req, w_disp_req;
    logic [1:0]    r_disp_item, w_disp_item;
    logic          r_chg_req, w_chg_req;
    logic          r_coin_rej, w_coin_rej;
    logic          r_no_funds, w_no_funds;
    logic          r_err, w_err;
    logic [CW-1:0] r_cnt, w_cnt;

    logic          w_coin_ev;
    logic [4:0]    w_coin_amt;
    logic [5:0]    w_sum;
    logic [4:0]    w_sel_price;
    logic [4:0]    w_item_price;

    function automatic logic [4:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 5'(PRICE0);
            2'd1:    return 5'(PRICE1);
            2'd2:    return 5'(PRICE2);
            default: return 5'(PRICE3);
        endcase
    endfunction

    // Coin code 00 is treated as no coin at all, never as a rejected one.
    assign w_coin_ev    = coin_valid && (coin_val != 2'b00);
    assign w_coin_amt   = (coin_val == 2'b11) ? 5'd5 : {3'b000, coin_val};
    assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_amt};
    assign w_sel_price  = price_of(sel);
    assign w_item_price = price_of(r_disp_item);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_credit    <= 5'd0;
            r_disp_req  <= 1'b0;
            r_disp_item <= 2'd0;
            r_chg_req   <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_no_funds  <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state;
            r_credit    <= w_credit;
            r_disp_req  <= w_disp_req;
            r_disp_item <= w_disp_item;
            r_chg_req   <= w_chg_req;
            r_coin_rej  <= w_coin_rej;
            r_no_funds  <= w_no_funds;
            r_err       <= w_err;
            r_cnt       <= w_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_credit    = r_credit;
        w_disp_req  = r_disp_req;
        w_disp_item = r_disp_item;
        w_chg_req   = r_chg_req;
        w_coin_rej  = 1'b0;
        w_no_funds  = 1'b0;
        w_err       = r_err;
        w_cnt       = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_coin_ev) begin
                    w_credit = w_sum[4:0];
                    w_err    = 1'b0;
                    w_state  = S_CREDIT;
                end
            end
            S_CREDIT: begin
                // Priority: cancel, then coin, then selection.
                if (cancel) begin
                    w_coin_rej = w_coin_ev;
                    w_chg_req  = (r_credit != 5'd0);
                    w_state    = S_CHANGE;
                end else if (w_coin_ev) begin
                    if (w_sum > 6'd31) begin
                        w_coin_rej = 1'b1;
                    end else begin
                        w_credit = w_sum[4:0];
                    end
                end else if (sel_valid) begin
                    if (r_credit >= w_sel_price) begin
                        w_disp_item = sel;
                        w_credit    = r_credit - w_sel_price;
                        w_disp_req  = 1'b1;
                        w_cnt       = '0;
                        w_state     = S_DISPENSE;
                    end else begin
                        w_no_funds = 1'b1;
                    end
                end
            end
            S_DISPENSE: begin
                w_coin_rej = w_coin_ev;
                if (disp_ack) begin
                    w_disp_req = 1'b0;
                    if (r_credit != 5'd0) begin
                        w_chg_req = 1'b1;
                        w_state   = S_CHANGE;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    // Dispenser never answered: refund the item price as change.
                    w_disp_req = 1'b0;
                    w_credit   = r_credit + w_item_price;
                    w_err      = 1'b1;
                    w_chg_req  = 1'b1;
                    w_state    = S_CHANGE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_CHANGE: begin
                w_coin_rej = w_coin_ev;
                if (r_credit == 5'd0) begin
                    w_chg_req = 1'b0;
                    w_state   = S_IDLE;
                end else if (chg_ack) begin
                    w_credit = r_credit - 5'd1;
                    if (r_credit == 5'd1) begin
                        w_chg_req = 1'b0;
                        w_state   = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign ready     = (r_state == S_IDLE);
    assign credit    = r_credit;
    assign disp_req  = r_disp_req;
    assign disp_item = r_disp_item;
    assign chg_req   = r_chg_req;
    assign coin_rej  = r_coin_rej;
    assign no_funds  = r_no_funds;
    assign err       = r_err;

endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - directed vector bench for vend_sequencer
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_item;
    logic       chg_req;
    logic [4:0] credit;
    logic       ready;
    logic       coin_rej;
    logic       no_funds;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    vend_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .coin_valid(coin_valid),
        .coin_val  (coin_val),
        .sel_valid (sel_valid),
        .sel       (sel),
        .cancel    (cancel),
        .disp_ack  (disp_ack),
        .chg_ack   (chg_ack),
        .disp_req  (disp_req),
        .disp_item (disp_item),
        .chg_req   (chg_req),
        .credit    (credit),
        .ready     (ready),
        .coin_rej  (coin_rej),
        .no_funds  (no_funds),
        .err       (err)
    );

    always #5 clk = ~clk;

    // coin: -1 none, else coin code; sel: -1 none, else item index
    typedef struct {
        int coin;
        int sel;
        int cn;
        int da;
        int ca;
        int e_credit;
        int e_dreq;
        int e_item;
        int e_creq;
        int e_rej;
        int e_nf;
        int e_err;
        int e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int coin, input int sl, input int cn, input int da,
                                input int ca, input int c, input int dr, input int it,
                                input int cr, input int rj, input int nf, input int er,
                                input int rd);
        vec_t t;
        t.coin = coin; t.sel = sl; t.cn = cn; t.da = da; t.ca = ca;
        t.e_credit = c; t.e_dreq = dr; t.e_item = it; t.e_creq = cr;
        t.e_rej = rj; t.e_nf = nf; t.e_err = er; t.e_rdy = rd;
        return t;
    endfunction

    task automatic v(input int coin, input int sl, input int cn, input int da, input int ca,
                     input int c, input int dr, input int it, input int cr, input int rj,
                     input int nf, input int er, input int rd);
        tbl.push_back(mk(coin, sl, cn, da, ca, c, dr, it, cr, rj, nf, er, rd));
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic outs(input string tag, input vec_t t);
        chk({tag, ".credit"},    int'(credit),    t.e_credit);
        chk({tag, ".disp_req"},  int'(disp_req),  t.e_dreq);
        chk({tag, ".disp_item"}, int'(disp_item), t.e_item);
        chk({tag, ".chg_req"},   int'(chg_req),   t.e_creq);
        chk({tag, ".coin_rej"},  int'(coin_rej),  t.e_rej);
        chk({tag, ".no_funds"},  int'(no_funds),  t.e_nf);
        chk({tag, ".err"},       int'(err),       t.e_err);
        chk({tag, ".ready"},     int'(ready),     t.e_rdy);
    endtask

    task automatic run(input vec_t t, input string tag);
        coin_valid = (t.coin >= 0);
        coin_val   = (t.coin >= 0) ? 2'(t.coin) : 2'b00;
        sel_valid  = (t.sel >= 0);
        sel        = (t.sel >= 0) ? 2'(t.sel) : 2'b00;
        cancel     = t.cn[0];
        disp_ack   = t.da[0];
        chg_ack    = t.ca[0];
        @(posedge clk);
        #1;
        outs(tag, t);
    endtask

    initial begin
        // Reset state (held across an edge)
        @(posedge clk);
        #1;
        outs("reset", mk(-1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b0;

        // coins 2+2, sel 0, ack on 3rd disp_req cycle, one change unit
        v(-1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        v( 0,-1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        v( 2,-1, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        v( 2,-1, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 0);
        v(-1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        v( 1,-1, 0, 0, 0,  1, 1, 0, 0, 1, 0, 0, 0);
        v(-1,-1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        v(-1,-1, 0, 1, 0,  1, 0, 0, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1);
        v(-1,-1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1);
        // exact price, cancel ignored in DISPENSE, ack with zero credit -> IDLE
        v( 2,-1, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        v( 2,-1, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 0);
        v(-1, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0);
        v(-1,-1, 1, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0);
        v(-1,-1, 0, 1, 0,  0, 0, 1, 0, 0, 0, 0, 1);
        // credit 5, sel 3 -> no_funds; cancel -> 5 change units
        v( 3,-1, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0, 0);
        v(-1, 3, 0, 0, 0,  5, 0, 1, 0, 0, 1, 0, 0);
        v(-1,-1, 0, 0, 0,  5, 0, 1, 0, 0, 0, 0, 0);
        v(-1,-1, 1, 0, 0,  5, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  4, 0, 1, 1, 0, 0, 0, 0);
        v( 1,-1, 0, 0, 0,  4, 0, 1, 1, 1, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  3, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  2, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 1);
        // coin beats sel; cancel beats coin and sel at credit 4
        v( 2,-1, 0, 0, 0,  2, 0, 1, 0, 0, 0, 0, 0);
        v( 1, 0, 0, 0, 0,  3, 0, 1, 0, 0, 0, 0, 0);
        v( 1,-1, 0, 0, 0,  4, 0, 1, 0, 0, 0, 0, 0);
        v( 1, 0, 1, 0, 0,  4, 0, 1, 1, 1, 0, 0, 0);
        v(-1,-1, 0, 0, 0,  4, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  3, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  2, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  1, 0, 1, 1, 0, 0, 0, 0);
        v(-1,-1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0, 1);
        // credit ceiling of 31
        for (int i = 1; i <= 6; i++) v(3, -1, 0, 0, 0, 5 * i, 0, 1, 0, 0, 0, 0, 0);
        v( 3,-1, 0, 0, 0, 30, 0, 1, 0, 1, 0, 0, 0);
        v( 1,-1, 0, 0, 0, 31, 0, 1, 0, 0, 0, 0, 0);
        v( 1,-1, 0, 0, 0, 31, 0, 1, 0, 1, 0, 0, 0);
        v(-1,-1, 1, 0, 0, 31, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 31; i++)
            v(-1, -1, 0, 0, 1, 31 - i, 0, 1, int'(i != 31), 0, 0, 0, int'(i == 31));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Dispense timeout: 15 cycles without ack -> refund, err, change
        run(mk( 3,-1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0), "to_coin5");
        run(mk( 1,-1, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0), "to_coin1");
        run(mk(-1, 2, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), "to_sel2");
        for (int i = 1; i <= 14; i++)
            run(mk(-1, -1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), $sformatf("to_wait%0d", i));
        run(mk(-1,-1, 0, 0, 0, 6, 0, 2, 1, 0, 0, 1, 0), "to_expire");
        for (int i = 1; i <= 6; i++)
            run(mk(-1, -1, 0, 0, 1, 6 - i, 0, 2, int'(i != 6), 0, 0, 1, int'(i == 6)),
                $sformatf("to_refund%0d", i));
        run(mk( 1,-1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0), "to_errclr");

        // Asynchronous reset in the middle of CHANGE at credit 3
        run(mk( 2,-1, 0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0), "rs_coin2");
        run(mk(-1,-1, 1, 0, 0, 3, 0, 2, 1, 0, 0, 0, 0), "rs_cancel");
        run(mk(-1,-1, 0, 0, 0, 3, 0, 2, 1, 0, 0, 0, 0), "rs_hold");
        chg_ack = 1'b1;
        coin_valid = 1'b1;
        coin_val = 2'b01;
        #3;
        rst = 1'b1;
        #1;
        outs("rs_async", mk(-1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        coin_valid = 1'b0;
        coin_val = 2'b00;
        outs("rs_held", mk(-1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rst = 1'b0;
        run(mk(-1,-1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "rs_release");
        run(mk(-1,-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "rs_quiet");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE0, default 3, price of item 0 in credit units.
REQ-002 SHALL have parameters PRICE1 (default 4), PRICE2 (default 6), PRICE3 (default 9), prices of items 1-3.
REQ-003 SHALL have parameter TIMEOUT, default 15, max cycles to wait for disp_ack.
REQ-004 SHALL have port clk, input, 1 bit, single system clock; all state changes on rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 SHALL have port coin_valid, input, 1 bit, coin present this cycle.
REQ-007 SHALL have port coin_val, input, 2 bits, coin code: 01=1, 10=2, 11=5 units, 00=invalid.
REQ-008 SHALL have ports sel_valid (input, 1) and sel (input, 2), product selection strobe and item index.
REQ-009 SHALL have port cancel, input, 1 bit, refund request.
REQ-010 SHALL have ports disp_ack (input, 1), dispenser done, and chg_ack (input, 1), one change unit ejected.
REQ-011 SHALL have ports disp_req (output, 1) and disp_item (output, 2), dispense request and latched item.
REQ-012 SHALL have port chg_req, output, 1 bit, change unit request.
REQ-013 SHALL have port credit, output, 5 bits, current credit.
REQ-014 SHALL have ports ready (output, 1), coin_rej (output, 1), no_funds (output, 1) and err (output, 1).

Function
REQ-015 SHALL implement states IDLE, CREDIT, DISPENSE, CHANGE; ready = 1 only in IDLE.
REQ-016 SHALL treat coin_valid with coin_val=00 as no event, with no coin_rej.
REQ-017 IDLE: a valid coin SHALL add its value to credit and move to CREDIT; sel_valid and cancel are ignored.
REQ-018 CREDIT: a valid coin SHALL add its value; if the sum exceeds 31, credit is unchanged and coin_rej pulses 1 cycle.
REQ-019 CREDIT: on sel_valid with credit >= PRICE[sel], it SHALL latch disp_item=sel, subtract the price and enter DISPENSE.
REQ-020 CREDIT: on sel_valid with credit < PRICE[sel], it SHALL pulse no_funds 1 cycle and stay in CREDIT.
REQ-021 CREDIT: on cancel it SHALL enter CHANGE with credit unchanged.
REQ-022 CREDIT, same-cycle priority SHALL be cancel > coin > sel; a losing valid coin pulses coin_rej and a losing sel is dropped silently.
REQ-023 DISPENSE: disp_req SHALL be 1 from the first cycle in the state until the cycle disp_ack is sampled high.
REQ-024 DISPENSE: on disp_ack, it SHALL go to CHANGE if credit > 0, else to IDLE.
REQ-025 DISPENSE: a cycle counter SHALL start at 0 on entry; if TIMEOUT cycles pass without disp_ack, it SHALL add the price back to credit, set err and enter CHANGE.
REQ-026 DISPENSE: cancel SHALL be ignored.
REQ-027 CHANGE: chg_req SHALL be 1 while credit > 0; each cycle with chg_ack high SHALL decrement credit by 1.
REQ-028 CHANGE: when credit reaches 0, it SHALL deassert chg_req the next cycle and enter IDLE; chg_ack at credit 0 is ignored.
REQ-029 In DISPENSE and CHANGE, every valid coin SHALL pulse coin_rej and leave credit unchanged.
REQ-030 err SHALL be sticky and clear only on reset or on the next coin accepted in IDLE.
REQ-031 Accepted coins and selections SHALL show on credit/disp_req one cycle after the sampling edge; all outputs SHALL be registered except ready.

Reset
REQ-032 rst high SHALL force IDLE immediately, with credit=0, disp_req=0, disp_item=0, chg_req=0, coin_rej=0, no_funds=0, err=0, ready=1.
REQ-033 Reset mid-DISPENSE or mid-CHANGE SHALL abort the transaction with no refund, and no output pulse SHALL follow reset release.

Verification
REQ-034 Bench SHALL cover: coins 2+2, sel=0, disp_ack after 3 cycles -> credit 4->1, disp_req 3 cycles, disp_item=0, then 1 chg_req/chg_ack, then IDLE with ready=1.
REQ-035 Bench SHALL cover: credit 5, sel=3 -> no_funds 1-cycle pulse, credit stays 5; then cancel -> 5 chg_ack cycles, then IDLE.
REQ-036 Bench SHALL cover: credit 30, coin 5 -> coin_rej pulse, credit 30; coin 1 -> credit 31.
REQ-037 Bench SHALL cover: credit 6, sel=2, no disp_ack for 15 cycles -> err=1, credit 6, CHANGE refunds 6; err clears on next IDLE coin.
REQ-038 Bench SHALL cover: same-cycle cancel+coin+sel with credit 4 -> coin_rej pulse, CHANGE with credit 4, no disp_req.
REQ-039 Bench SHALL cover: rst asserted mid-CHANGE at credit 3 -> outputs at reset values asynchronously, ready=1 after release.
